// File: rtl/bus_master.sv
// Burst-capable bus master: requests the bus, issues 1..16 incrementing read or
// write beats, and folds read data into a running checksum.
module bus_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op_wr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        len,
  input  logic [DATA_W-1:0] wseed,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rsum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    RLAST = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic                op_wr_r, op_wr_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [3:0]          idx_r, idx_s;
  logic [3:0]          last_r, last_s;
  logic [DATA_W-1:0]   seed_r, seed_s;
  logic                rd_pend_r, rd_pend_s;
  logic [DATA_W-1:0]   rsum_s;
  logic                xfer_s;
  logic                m_req_s, m_wr_s, busy_s, done_s;
  logic [ADDR_W-1:0]   m_addr_s;
  logic [DATA_W-1:0]   m_dout_s;

  // Next-state, burst bookkeeping and checksum update.
  always_comb begin
    state_s   = state_r;
    op_wr_s   = op_wr_r;
    addr_s    = addr_r;
    idx_s     = idx_r;
    last_s    = last_r;
    seed_s    = seed_r;
    rd_pend_s = 1'b0;
    // Read data arrives the cycle after its beat was accepted.
    if (rd_pend_r) begin
      rsum_s = rsum + m_din;
    end else begin
      rsum_s = rsum;
    end
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = REQ;
          op_wr_s = op_wr;
          addr_s  = start_addr;
          last_s  = len - 4'd1;  // len 0 wraps to index 15, i.e. 16 beats
          seed_s  = wseed;
          idx_s   = 4'd0;
          rsum_s  = {DATA_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (m_grant) begin
          state_s = XFER;
        end else begin
          state_s = REQ;
        end
      end
      XFER: begin
        if (m_grant) begin
          addr_s    = addr_r + ADDR_W'(1);
          idx_s     = idx_r + 4'd1;
          rd_pend_s = ~op_wr_r;
          if (idx_r == last_r) begin
            state_s = op_wr_r ? DONE : RLAST;
          end else begin
            state_s = XFER;
          end
        end else begin
          state_s = XFER;
        end
      end
      RLAST:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, so every output leaves a flop.
  always_comb begin
    xfer_s   = (state_s == XFER);
    m_req_s  = (state_s == REQ) || xfer_s;
    m_wr_s   = xfer_s && op_wr_s;
    m_addr_s = xfer_s ? addr_s : {ADDR_W{1'b0}};
    m_dout_s = (xfer_s && op_wr_s) ? (seed_s + DATA_W'(idx_s)) : {DATA_W{1'b0}};
    busy_s   = (state_s != IDLE);
    done_s   = (state_s == DONE);
  end

  // State, burst context and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      op_wr_r   <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      idx_r     <= 4'd0;
      last_r    <= 4'd0;
      seed_r    <= {DATA_W{1'b0}};
      rd_pend_r <= 1'b0;
      rsum      <= {DATA_W{1'b0}};
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= {ADDR_W{1'b0}};
      m_dout    <= {DATA_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      op_wr_r   <= op_wr_s;
      addr_r    <= addr_s;
      idx_r     <= idx_s;
      last_r    <= last_s;
      seed_r    <= seed_s;
      rd_pend_r <= rd_pend_s;
      rsum      <= rsum_s;
      m_req     <= m_req_s;
      m_wr      <= m_wr_s;
      m_addr    <= m_addr_s;
      m_dout    <= m_dout_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule
